fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch queue directly downstream of the fetch unit and instruction ROM.
- Captures each fetched {pc, instruction} pair into a small FIFO and presents them in order to the decode stage through a valid/ready handshake.
- Asserts backpressure (full) so the fetch unit can hold PC.
- Discards all queued entries on a taken jump (flush), so decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- inPc  input  32  PC of the fetched instruction (fetch unit pc).
- inInst  input  32  instruction word read from ROM at inPc.
- inValid  input  1  inPc/inInst valid this cycle (ROM enabled and not stalled).
- flush  input  1  taken jump (same signal as fetch jump enable); squashes queue.
- outReady  input  1  decode accepts the head entry this cycle.
- outPc  output  32  PC of head entry.
- outInst  output  32  instruction of head entry.
- outValid  output  1  head entry valid.
- full  output  1  queue holds DEPTH entries; fetch unit must hold PC.
- count  output  AW+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (rst=1 at clk edge): wrPtr=0, rdPtr=0, count=0 → outValid=0, full=0, outPc=0, outInst=0. Storage array contents are not reset.
- push = inValid && !full && !flush.
- pop = outValid && outReady && !flush.
- Push writes {inPc, inInst} at wrPtr; wrPtr increments modulo DEPTH (natural AW-bit wrap).
- Pop increments rdPtr modulo DEPTH.
- count next:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- full = (count == DEPTH) and outValid = (count != 0). Both are combinational from registered count.
- outPc/outInst = storage[rdPtr], combinational read; 0 when count==0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N. There is no same-cycle bypass from input to output.
- Full boundary:
  - With count==DEPTH, push is blocked even if pop occurs that cycle; the input is dropped.
  - The fetch unit must not advance PC while full=1.
  - A pop while full drops count to DEPTH-1, and full deasserts the next cycle.
- Empty boundary:
  - With count==0, outValid=0, and outReady is ignored (no pop, no underflow).
  - A push while empty makes outValid=1 the next cycle.
- Flush:
  - flush=1 at an edge sets wrPtr=rdPtr=0 and count=0.
  - Any concurrent push and pop are suppressed; flush dominates both.
  - The next cycle has outValid=0, full=0.
  - The jump-target instruction arrives on inValid on a later cycle and is pushed normally.
- Reset dominates flush. rst asserted mid-operation discards all entries at that edge, regardless of inValid/outReady/flush.
- Wrap-around: pointers wrap silently. Ordering is strictly FIFO across wrap. count never exceeds DEPTH or goes below 0.
- No internal state machine beyond pointers and count. The occupancy states EMPTY (0), PARTIAL (1..DEPTH-1) and FULL (DEPTH) follow from count with the transitions above.

Decomposition:
- Shared package: instruction width (32), PC width (32), reset PC value (32'h0). Fetch unit and decode use the same constants.
- Natural sub-module: fetch_queue_mem, a DEPTH×64 register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). The top level holds pointers, count, flush and handshake logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, inValid=0 → outValid=0, full=0, count=0, outPc=0, outInst=0.
- Fill to full with outReady=0: push pc 0x0,0x4,0x8,0xC (inst 0x11111111..0x44444444) → count=4 and full=1 after the 4th edge. A 5th push (pc 0x10) is dropped; the head stays pc=0x0.
- Drain in order: after the fill, outReady=1 → outPc sequence 0x0,0x4,0x8,0xC on consecutive cycles, then outValid=0, count=0.
- Simultaneous push/pop at count=2 (heads 0x0,0x4): push pc 0x8 while popping → count stays 2, next head pc=0x4. Repeat across ≥2 wraps; the sequence stays monotonic +4.
- Flush mid-stream: count=3, flush=1 with inValid=1 (pc 0x20) and outReady=1 → next cycle count=0, outValid=0, full=0, pc 0x20 not stored. Then push target pc 0x100 → head pc=0x100 one cycle later.
- Reset mid-operation: count=4, full=1, assert rst together with flush and outReady → count=0, outValid=0, full=0 after that edge. The first post-reset push of pc 0x0 appears as head.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode constants and the queue entry bundle.
// Fetch unit, fetch queue and decode all import this package.
package fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: one write port, one asynchronous read port.
// Contents are intentionally left unreset.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order {pc, inst} queue between fetch and decode.
// Flush on a taken jump squashes every queued entry.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   inPc,
  input  logic [INST_W-1:0] inInst,
  input  logic              inValid,
  input  logic              flush,
  input  logic              outReady,
  output logic [PC_W-1:0]   outPc,
  output logic [INST_W-1:0] outInst,
  output logic              outValid,
  output logic              full,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     rd_entry;

  assign full     = (cnt == FULL_CNT);
  assign outValid = (cnt != '0);
  assign count    = cnt;

  // Flush wins over both handshakes; full blocks push even on a pop.
  assign push = inValid && !full && !flush;
  assign pop  = outValid && outReady && !flush;

  assign wr_entry.pc   = inPc;
  assign wr_entry.inst = inInst;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign outPc   = outValid ? rd_entry.pc   : RESET_PC;
  assign outInst = outValid ? rd_entry.inst : '0;

endmodule
